// File: rtl/bster_pkg.sv
// Shared types for the tree space manager and its front end.
// FSM encodings and the reserved root node address.
package bster_pkg;

   typedef enum logic [1:0] {
      A_IDLE,
      A_REQ,
      A_RESP
   } alloc_state_t;

   typedef enum logic {
      F_IDLE,
      F_FWD
   } free_state_t;

   localparam int ROOT_ADDR = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
// Returns one-hot grant, grant index and any-request flag.
module rr_arbiter #(
   parameter int NB_ENGINE = 4,
   parameter int PW        = $clog2(NB_ENGINE)
) (
   input  logic [NB_ENGINE-1:0] i_req,
   input  logic [PW-1:0]        i_ptr,
   output logic [NB_ENGINE-1:0] o_gnt,
   output logic [PW-1:0]        o_idx,
   output logic                 o_any
);

   logic [PW-1:0] w_j;

   assign o_any = |i_req;

   // Walk from the farthest offset back to the pointer so the nearest wins.
   always_comb begin
      o_idx = '0;
      w_j   = '0;
      for (int k = NB_ENGINE - 1; k >= 0; k--) begin
         w_j = PW'((int'(i_ptr) + k) % NB_ENGINE);
         if (i_req[w_j]) o_idx = w_j;
      end
      o_gnt = o_any ? (NB_ENGINE'(1) << o_idx) : '0;
   end

endmodule

// File: rtl/tree_space_arbiter.sv
// Arbitrates N engines onto the space manager's alloc and free ports.
// Each path has its own round-robin pointer and FSM.
module tree_space_arbiter #(
   parameter int NB_ENGINE      = 4,
   parameter int RAM_ADDR_WIDTH = 16
) (
   input  logic                                aclk,
   input  logic                                aresetn,
   input  logic [NB_ENGINE-1:0]                eng_req_valid,
   output logic [NB_ENGINE-1:0]                eng_req_ready,
   output logic [RAM_ADDR_WIDTH-1:0]           eng_req_addr,
   input  logic [NB_ENGINE-1:0]                eng_free_valid,
   output logic [NB_ENGINE-1:0]                eng_free_ready,
   input  logic [NB_ENGINE*RAM_ADDR_WIDTH-1:0] eng_free_addr,
   output logic                                tree_mgt_req_valid,
   input  logic                                tree_mgt_req_ready,
   input  logic [RAM_ADDR_WIDTH-1:0]           tree_mgt_req_addr,
   output logic                                tree_mgt_free_valid,
   input  logic                                tree_mgt_free_ready,
   output logic [RAM_ADDR_WIDTH-1:0]           tree_mgt_free_addr
);

   import bster_pkg::*;

   localparam int PW = $clog2(NB_ENGINE);

   alloc_state_t              r_a_st;
   logic [PW-1:0]             r_a_ptr;
   logic [PW-1:0]             r_a_gnt;
   logic [NB_ENGINE-1:0]      r_a_oh;
   logic [RAM_ADDR_WIDTH-1:0] r_a_addr;

   free_state_t               r_f_st;
   logic [PW-1:0]             r_f_ptr;
   logic [RAM_ADDR_WIDTH-1:0] r_f_addr;

   logic [NB_ENGINE-1:0]      w_a_oh;
   logic [PW-1:0]             w_a_idx;
   logic                      w_a_any;
   logic [NB_ENGINE-1:0]      w_f_oh;
   logic [PW-1:0]             w_f_idx;
   logic                      w_f_any;
   logic [RAM_ADDR_WIDTH-1:0] w_f_addr;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(NB_ENGINE - 1)) ? '0 : p + PW'(1);
   endfunction

   rr_arbiter #(.NB_ENGINE(NB_ENGINE), .PW(PW)) u_a_arb (
      .i_req (eng_req_valid),
      .i_ptr (r_a_ptr),
      .o_gnt (w_a_oh),
      .o_idx (w_a_idx),
      .o_any (w_a_any)
   );

   rr_arbiter #(.NB_ENGINE(NB_ENGINE), .PW(PW)) u_f_arb (
      .i_req (eng_free_valid),
      .i_ptr (r_f_ptr),
      .o_gnt (w_f_oh),
      .o_idx (w_f_idx),
      .o_any (w_f_any)
   );

   always_comb begin
      w_f_addr = '0;
      for (int i = 0; i < NB_ENGINE; i++) begin
         if (w_f_idx == PW'(i))
            w_f_addr = eng_free_addr[i*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_a_st   <= A_IDLE;
         r_a_ptr  <= '0;
         r_a_gnt  <= '0;
         r_a_oh   <= '0;
         r_a_addr <= '0;
      end else begin
         unique case (r_a_st)
            A_IDLE: if (w_a_any) begin
               r_a_gnt <= w_a_idx;
               r_a_oh  <= w_a_oh;
               r_a_st  <= A_REQ;
            end
            A_REQ: if (tree_mgt_req_ready) begin
               r_a_addr <= tree_mgt_req_addr;
               r_a_st   <= A_RESP;
            end
            A_RESP: begin
               r_a_ptr <= nxt(r_a_gnt);
               r_a_st  <= A_IDLE;
            end
            default: r_a_st <= A_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_f_st   <= F_IDLE;
         r_f_ptr  <= '0;
         r_f_addr <= '0;
      end else begin
         unique case (r_f_st)
            F_IDLE: if (w_f_any) begin
               r_f_addr <= w_f_addr;
               r_f_ptr  <= nxt(w_f_idx);
               r_f_st   <= F_FWD;
            end
            F_FWD: if (tree_mgt_free_ready) r_f_st <= F_IDLE;
            default: r_f_st <= F_IDLE;
         endcase
      end
   end

   assign tree_mgt_req_valid  = (r_a_st == A_REQ);
   assign eng_req_ready       = (r_a_st == A_RESP) ? r_a_oh : '0;
   assign eng_req_addr        = r_a_addr;
   // Free accept is combinational; keep it quiet while reset is held.
   assign eng_free_ready      = (aresetn && r_f_st == F_IDLE) ? w_f_oh : '0;
   assign tree_mgt_free_valid = (r_f_st == F_FWD) && tree_mgt_free_ready;
   assign tree_mgt_free_addr  = r_f_addr;

endmodule

// File: tb/tb_tree_space_arbiter.sv
// Directed bench for tree_space_arbiter, NB_ENGINE=4, 8-bit addresses.
// Inputs change 1ns after the rising edge, outputs checked 1ns later.
module tb_tree_space_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           aclk;
   logic           aresetn;
   logic [N-1:0]   eng_req_valid;
   logic [N-1:0]   eng_req_ready;
   logic [W-1:0]   eng_req_addr;
   logic [N-1:0]   eng_free_valid;
   logic [N-1:0]   eng_free_ready;
   logic [N*W-1:0] eng_free_addr;
   logic           tree_mgt_req_valid;
   logic           tree_mgt_req_ready;
   logic [W-1:0]   tree_mgt_req_addr;
   logic           tree_mgt_free_valid;
   logic           tree_mgt_free_ready;
   logic [W-1:0]   tree_mgt_free_addr;

   int n_err = 0;
   int n_chk = 0;

   tree_space_arbiter #(.NB_ENGINE(N), .RAM_ADDR_WIDTH(W)) dut (
      .aclk                (aclk),
      .aresetn             (aresetn),
      .eng_req_valid       (eng_req_valid),
      .eng_req_ready       (eng_req_ready),
      .eng_req_addr        (eng_req_addr),
      .eng_free_valid      (eng_free_valid),
      .eng_free_ready      (eng_free_ready),
      .eng_free_addr       (eng_free_addr),
      .tree_mgt_req_valid  (tree_mgt_req_valid),
      .tree_mgt_req_ready  (tree_mgt_req_ready),
      .tree_mgt_req_addr   (tree_mgt_req_addr),
      .tree_mgt_free_valid (tree_mgt_free_valid),
      .tree_mgt_free_ready (tree_mgt_free_ready),
      .tree_mgt_free_addr  (tree_mgt_free_addr)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      eng_req_valid       = '0;
      eng_free_valid      = '0;
      eng_free_addr       = '0;
      tree_mgt_req_ready  = 1'b1;
      tree_mgt_req_addr   = '0;
      tree_mgt_free_ready = 1'b1;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      tick();
      tick();
      idle_inputs();
      aresetn = 1'b1;
      settle();
   endtask

   initial begin
      // Reset defaults with busy inputs
      aresetn             = 1'b0;
      eng_req_valid       = 4'hF;
      eng_free_valid      = 4'hA;
      eng_free_addr       = 32'h5A3C_96E1;
      tree_mgt_req_ready  = 1'b1;
      tree_mgt_req_addr   = 8'hC3;
      tree_mgt_free_ready = 1'b1;
      tick();
      tick();
      chk("rst_req_ready", 32'(eng_req_ready), 32'h0);
      chk("rst_free_ready", 32'(eng_free_ready), 32'h0);
      chk("rst_req_addr", 32'(eng_req_addr), 32'h0);
      chk("rst_mreq_valid", 32'(tree_mgt_req_valid), 32'h0);
      chk("rst_mfree_valid", 32'(tree_mgt_free_valid), 32'h0);
      chk("rst_mfree_addr", 32'(tree_mgt_free_addr), 32'h0);
      idle_inputs();
      aresetn = 1'b1;
      tick();
      tick();
      chk("post_rst_mreq", 32'(tree_mgt_req_valid), 32'h0);

      // Single allocation for engine 2
      eng_req_valid     = 4'b0100;
      tree_mgt_req_addr = 8'h05;
      tick();
      chk("a1_mreq_c1", 32'(tree_mgt_req_valid), 32'h1);
      chk("a1_rdy_c1", 32'(eng_req_ready), 32'h0);
      tick();
      chk("a1_rdy_c2", 32'(eng_req_ready), 32'h4);
      chk("a1_addr_c2", 32'(eng_req_addr), 32'h05);
      chk("a1_mreq_c2", 32'(tree_mgt_req_valid), 32'h0);
      eng_req_valid = '0;
      tick();
      chk("a1_rdy_c3", 32'(eng_req_ready), 32'h0);
      chk("a1_mreq_c3", 32'(tree_mgt_req_valid), 32'h0);

      // Fairness: all engines request continuously
      do_reset();
      eng_req_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         tree_mgt_req_addr = W'(k);
         tick();
         chk($sformatf("fair%0d_mreq", k), 32'(tree_mgt_req_valid), 32'h1);
         tick();
         chk($sformatf("fair%0d_rdy", k), 32'(eng_req_ready),
             32'(1 << (k % N)));
         chk($sformatf("fair%0d_addr", k), 32'(eng_req_addr), 32'(k));
         tick();
         chk($sformatf("fair%0d_idle", k), 32'(eng_req_ready), 32'h0);
      end
      eng_req_valid = '0;

      // Manager exhausted for 10 cycles
      do_reset();
      eng_req_valid      = 4'b0010;
      tree_mgt_req_ready = 1'b0;
      tree_mgt_req_addr  = 8'h77;
      tick();
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("stall%0d", i),
             32'({tree_mgt_req_valid, eng_req_ready}), 32'h10);
         if (i < 9) tick();
      end
      tree_mgt_req_ready = 1'b1;
      tick();
      chk("stall_rdy", 32'(eng_req_ready), 32'h2);
      chk("stall_addr", 32'(eng_req_addr), 32'h77);
      eng_req_valid = '0;
      tick();

      // Free path with the manager FIFO full
      do_reset();
      eng_free_valid      = 4'b1010;
      eng_free_addr       = 32'h3300_2200;
      tree_mgt_free_ready = 1'b0;
      settle();
      chk("f_acc1", 32'(eng_free_ready), 32'h2);
      tick();
      eng_free_valid = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk($sformatf("f_full%0d", i),
             32'({tree_mgt_free_valid, eng_free_ready}), 32'h0);
         tick();
      end
      tree_mgt_free_ready = 1'b1;
      settle();
      chk("f_push1_v", 32'(tree_mgt_free_valid), 32'h1);
      chk("f_push1_a", 32'(tree_mgt_free_addr), 32'h22);
      chk("f_push1_r", 32'(eng_free_ready), 32'h0);
      tick();
      chk("f_acc3", 32'(eng_free_ready), 32'h8);
      chk("f_gap_v", 32'(tree_mgt_free_valid), 32'h0);
      tick();
      eng_free_valid = '0;
      settle();
      chk("f_push3_v", 32'(tree_mgt_free_valid), 32'h1);
      chk("f_push3_a", 32'(tree_mgt_free_addr), 32'h33);
      tick();
      chk("f_done", 32'({tree_mgt_free_valid, eng_free_ready}), 32'h0);

      // Concurrent alloc and free from engine 0
      do_reset();
      eng_req_valid     = 4'b0001;
      eng_free_valid    = 4'b0001;
      eng_free_addr     = 32'h0000_0010;
      tree_mgt_req_addr = 8'h44;
      settle();
      chk("cc_facc", 32'(eng_free_ready), 32'h1);
      tick();
      eng_free_valid = '0;
      settle();
      chk("cc_mreq", 32'(tree_mgt_req_valid), 32'h1);
      chk("cc_mfree", 32'(tree_mgt_free_valid), 32'h1);
      chk("cc_faddr", 32'(tree_mgt_free_addr), 32'h10);
      tick();
      chk("cc_rdy", 32'(eng_req_ready), 32'h1);
      chk("cc_addr", 32'(eng_req_addr), 32'h44);
      chk("cc_mfree_off", 32'(tree_mgt_free_valid), 32'h0);
      eng_req_valid = '0;
      tick();
      chk("cc_rdy_off", 32'(eng_req_ready), 32'h0);

      // Reset while waiting in A_REQ
      eng_req_valid      = 4'b0010;
      tree_mgt_req_ready = 1'b0;
      tick();
      chk("mr_inreq", 32'(tree_mgt_req_valid), 32'h1);
      aresetn = 1'b0;
      settle();
      chk("mr_mreq", 32'(tree_mgt_req_valid), 32'h0);
      chk("mr_addr", 32'(eng_req_addr), 32'h0);
      tick();
      eng_req_valid      = '0;
      tree_mgt_req_ready = 1'b1;
      aresetn            = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("mr_quiet%0d", i),
             32'({tree_mgt_req_valid, eng_req_ready}), 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
